// File: rtl/decoder_pkg.sv
// decoder_pkg: load/store size encodings shared with the decoder,
// plus the LSU FSM state type and byte-enable/alignment helpers.
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    FIRST_WAIT,
    SECOND,
    SECOND_WAIT
  } lsu_state_t;

  // Unshifted byte enables; reserved sizes act as word.
  function automatic logic [3:0] be_base(
    input logic [2:0] size
  );
    unique case (size)
      LDST_B, LDST_BU: be_base = 4'b0001;
      LDST_H, LDST_HU: be_base = 4'b0011;
      default:         be_base = 4'b1111;
    endcase
  endfunction

  // True when the access crosses a word boundary.
  function automatic logic is_misaligned(
    input logic [2:0] size,
    input logic [1:0] off
  );
    unique case (size)
      LDST_B, LDST_BU: is_misaligned = 1'b0;
      LDST_H, LDST_HU: is_misaligned = (off == 2'd3);
      default:         is_misaligned = (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_rd_extract.sv
// lsu_rd_extract: picks the addressed bytes out of a 64-bit window
// and sign/zero-extends them to 32 bits.
// Ports: off   - byte offset of the access inside the low word
//        size  - LDST_* size encoding
//        win   - {upper word, lower word} of read data
//        rd    - extended load result
module lsu_rd_extract
  import decoder_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [63:0] win,
  output logic [31:0] rd
);

  logic [63:0] sh;
  logic [31:0] lane;

  always_comb begin
    sh   = win >> {off, 3'b000};
    lane = sh[31:0];
    unique case (size)
      LDST_B:  rd = {{24{lane[7]}}, lane[7:0]};
      LDST_BU: rd = {24'h0, lane[7:0]};
      LDST_H:  rd = {{16{lane[15]}}, lane[15:0]};
      LDST_HU: rd = {16'h0, lane[15:0]};
      default: rd = lane;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// lsu_split: load/store unit in front of data_mem. Aligns core
// accesses to word transactions and splits word-crossing ones.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned
// accesses; when undefined they are flagged and not issued).
// Ports: clk_i/rst_i       - clock, sync active-high reset
//        core_req_i..wd_i  - core request (held while stalled)
//        core_rd_o         - extended load result
//        core_stall_o      - core must hold its request
//        core_misalign_o   - misaligned access rejected
//        mem_*_o           - word-aligned memory request
//        mem_rd_i          - read data, one cycle after accept
//        mem_ready_i       - memory accepts request this cycle
module lsu_split
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  lsu_state_t        state;
  lsu_state_t        state_nx;
  logic              rst_q;
  logic              quiet;
  logic [31:0]       lo_buf;
  logic              cap;
  logic [1:0]        off;
  logic              mis;
  logic [7:0]        be_sh;
  logic [63:0]       wd_sh;
  logic [ADDR_W-1:0] base_addr;
  logic [63:0]       win;

  assign off       = core_addr_i[1:0];
  assign mis       = is_misaligned(core_size_i, off);
  assign be_sh     = {4'b0000, be_base(core_size_i)} << off;
  assign wd_sh     = {core_wd_i, core_wd_i} << {off, 3'b000};
  assign base_addr = {core_addr_i[ADDR_W-1:2], 2'b00};
  assign mem_we_o  = core_we_i;

  // Outputs stay silent during reset and for one cycle after it,
  // even if the core still presents a request.
  assign quiet = rst_i | rst_q;

  always_comb begin
    state_nx        = state;
    mem_req_o       = 1'b0;
    mem_addr_o      = base_addr;
    mem_be_o        = be_sh[3:0];
    mem_wd_o        = wd_sh[31:0];
    core_stall_o    = 1'b0;
    core_misalign_o = 1'b0;
    cap             = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req_i) begin
          if (mis && !SPLIT_EN) begin
            core_misalign_o = 1'b1;
          end else begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
            if (mem_ready_i) begin
              state_nx = FIRST_WAIT;
            end
          end
        end
      end
      FIRST_WAIT: begin
        if (mis && SPLIT_EN) begin
          core_stall_o = 1'b1;
          cap          = 1'b1;
          state_nx     = SECOND;
        end else begin
          state_nx = IDLE;
        end
      end
      SECOND: begin
        mem_req_o    = 1'b1;
        mem_addr_o   = base_addr + WORD;
        mem_be_o     = be_sh[7:4];
        mem_wd_o     = wd_sh[63:32];
        core_stall_o = 1'b1;
        if (mem_ready_i) begin
          state_nx = SECOND_WAIT;
        end
      end
      SECOND_WAIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (quiet) begin
      mem_req_o       = 1'b0;
      core_stall_o    = 1'b0;
      core_misalign_o = 1'b0;
      cap             = 1'b0;
      state_nx        = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rst_q  <= 1'b1;
      lo_buf <= 32'h0;
    end else begin
      state <= state_nx;
      rst_q <= 1'b0;
      if (cap) begin
        lo_buf <= mem_rd_i;
      end
    end
  end

  // Split reads see {second word, first word}; aligned reads
  // only ever touch the low word of the window.
  assign win = (state == SECOND_WAIT) ?
               {mem_rd_i, lo_buf} :
               {32'h0, mem_rd_i};

  lsu_rd_extract u_ext (
    .off  (off),
    .size (core_size_i),
    .win  (win),
    .rd   (core_rd_o)
  );

endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: directed scoreboard bench for lsu_split with a
// small word memory model answering the memory port.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_mis;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  always #5 clk = ~clk;

  lsu_split #(.ADDR_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .core_req_i      (core_req),
    .core_we_i       (core_we),
    .core_size_i     (core_size),
    .core_addr_i     (core_addr),
    .core_wd_i       (core_wd),
    .core_rd_o       (core_rd),
    .core_stall_o    (core_stall),
    .core_misalign_o (core_mis),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_be_o        (mem_be),
    .mem_addr_o      (mem_addr),
    .mem_wd_o        (mem_wd),
    .mem_rd_i        (mem_rd),
    .mem_ready_i     (mem_ready)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } rq_t;

  logic [31:0] mem [64];
  rq_t         obs_q[$];
  rq_t         exp_q[$];
  logic [31:0] exp_rd_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      obs_q.push_back('{mem_we, mem_addr, mem_be, mem_wd});
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end else begin
        mem_rd <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic exp_rq(input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    exp_q.push_back('{w, a, b, d});
  endtask

  task automatic chk_reqs(input string tag);
    rq_t e;
    rq_t o;
    chk({tag, " nreq"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, " addr"}, o.addr, e.addr);
      chk({tag, " we"}, 32'(o.we), 32'(e.we));
      if (e.we) begin
        chk({tag, " be"}, 32'(o.be), 32'(e.be));
        chk({tag, " wd"}, o.wd, e.wd);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // One core access; lat = cycles mem_ready is held low at start.
  task automatic acc(input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     input int lat, input int exp_st,
                     input string tag);
    int          st;
    logic [31:0] a0;
    logic [3:0]  b0;
    @(posedge clk); #1;
    core_req  = 1'b1;
    core_we   = w;
    core_size = sz;
    core_addr = a;
    core_wd   = d;
    mem_ready = (lat == 0);
    st = 0;
    a0 = '0;
    b0 = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, " mis"}, 32'(core_mis), 32'd0);
      if (!core_stall) break;
      st++;
      if (c == 0) begin
        a0 = mem_addr;
        b0 = mem_be;
      end else if (c <= lat) begin
        chk({tag, " hold addr"}, mem_addr, a0);
        chk({tag, " hold be"}, 32'(mem_be), 32'(b0));
        chk({tag, " hold req"}, 32'(mem_req), 32'd1);
      end
      @(posedge clk); #1;
      mem_ready = (c + 1 >= lat);
    end
    chk({tag, " stall"}, 32'(st), 32'(exp_st));
    if (!w) chk({tag, " rd"}, core_rd, exp_rd_q.pop_front());
    @(posedge clk); #1;
    core_req  = 1'b0;
    mem_ready = 1'b1;
    chk_reqs(tag);
  endtask

  task automatic st_w(input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    exp_rq(1'b1, a, 4'hF, d);
    acc(1'b1, 3'b010, a, d, 0, 1, tag);
  endtask

  task automatic ld(input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] r, input int lat,
                    input string tag);
    exp_rq(1'b0, {a[31:2], 2'b00}, 4'h0, 32'h0);
    exp_rd_q.push_back(r);
    acc(1'b0, sz, a, 32'h0, lat, 1 + lat, tag);
  endtask

`ifndef LSU_MISALIGN_SPLIT_EN
  task automatic mis_chk(input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input string tag);
    @(posedge clk); #1;
    core_req  = 1'b1;
    core_we   = w;
    core_size = sz;
    core_addr = a;
    core_wd   = 32'h5A5A5A5A;
    @(negedge clk);
    chk({tag, " mis"}, 32'(core_mis), 32'd1);
    chk({tag, " req"}, 32'(mem_req), 32'd0);
    chk({tag, " stall"}, 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    chk({tag, " mis2"}, 32'(core_mis), 32'd1);
    core_req = 1'b0;
    chk_reqs(tag);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h0;
    core_wd   = 32'h0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst stall", 32'(core_stall), 32'd0);
    chk("rst mis", 32'(core_mis), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst req", 32'(mem_req), 32'd0);
    chk("post rst stall", 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("idle req", 32'(mem_req), 32'd0);
    chk("idle stall", 32'(core_stall), 32'd0);
    chk_reqs("rst");

    st_w(32'h10, 32'h80FF0000, "sw10a");
    ld(3'b000, 32'h13, 32'hFFFFFF80, 0, "lb13");
    ld(3'b100, 32'h13, 32'h00000080, 0, "lbu13");
    ld(3'b001, 32'h12, 32'hFFFF80FF, 0, "lh12");
    ld(3'b101, 32'h12, 32'h000080FF, 0, "lhu12");

    st_w(32'h10, 32'hDEADBEEF, "sw10");
    ld(3'b010, 32'h10, 32'hDEADBEEF, 0, "lw10");
    ld(3'b010, 32'h10, 32'hDEADBEEF, 3, "lw10 wait");
    ld(3'b011, 32'h10, 32'hDEADBEEF, 0, "lw sz3");

    exp_rq(1'b1, 32'h04, 4'b1100, 32'h12340000);
    acc(1'b1, 3'b001, 32'h06, 32'hFFFF1234, 0, 1, "sh06");
    ld(3'b101, 32'h06, 32'h00001234, 0, "lhu06");
    ld(3'b001, 32'h06, 32'h00001234, 0, "lh06");
    exp_rq(1'b1, 32'h04, 4'b0010, 32'h00008000);
    acc(1'b1, 3'b000, 32'h05, 32'h00000080, 0, 1, "sb05");
    ld(3'b000, 32'h05, 32'hFFFFFF80, 0, "lb05");
    ld(3'b000, 32'h07, 32'h00000012, 0, "lb07");

    st_w(32'h0C, 32'hAABBCCDD, "sw0c");
    ld(3'b001, 32'h0D, 32'hFFFFBBCC, 0, "lh0d");

`ifndef LSU_MISALIGN_SPLIT_EN
    mis_chk(1'b0, 3'b010, 32'h0E, "mis lw0e");
    mis_chk(1'b0, 3'b001, 32'h0F, "mis lh0f");
    mis_chk(1'b0, 3'b101, 32'h0F, "mis lhu0f");
    mis_chk(1'b1, 3'b010, 32'h0F, "mis sw0f");
    mis_chk(1'b0, 3'b111, 32'h0E, "mis sz7");
    ld(3'b010, 32'h0C, 32'hAABBCCDD, 0, "lw0c kept");

    @(posedge clk); #1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h20;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstw stall", 32'(core_stall), 32'd1);
    chk("rstw req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw req0", 32'(mem_req), 32'd0);
    chk("rstw stall0", 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw after req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    core_req  = 1'b0;
    mem_ready = 1'b1;
    chk_reqs("rstw");
`else
    st_w(32'h10, 32'h11223344, "sw10b");
    exp_rq(1'b0, 32'h0C, 4'h0, 32'h0);
    exp_rq(1'b0, 32'h10, 4'h0, 32'h0);
    exp_rd_q.push_back(32'h3344AABB);
    acc(1'b0, 3'b010, 32'h0E, 32'h0, 0, 3, "split lw0e");

    exp_rq(1'b1, 32'h0C, 4'b1000, 32'h0D000000);
    exp_rq(1'b1, 32'h10, 4'b0111, 32'h0DCAFEF0);
    acc(1'b1, 3'b010, 32'h0F, 32'hCAFEF00D, 0, 3, "split sw0f");
    exp_rq(1'b0, 32'h0C, 4'h0, 32'h0);
    exp_rq(1'b0, 32'h10, 4'h0, 32'h0);
    exp_rd_q.push_back(32'hCAFEF00D);
    acc(1'b0, 3'b010, 32'h0F, 32'h0, 0, 3, "split lw0f");

    st_w(32'hFFFFFFFC, 32'h55667788, "swfc");
    st_w(32'h00000000, 32'h99AABBCC, "sw00");
    exp_rq(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
    exp_rq(1'b0, 32'h00000000, 4'h0, 32'h0);
    exp_rd_q.push_back(32'hBBCC5566);
    acc(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 3, "wrap lw");
    exp_rq(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
    exp_rq(1'b0, 32'h00000000, 4'h0, 32'h0);
    exp_rd_q.push_back(32'hFFFFCC55);
    acc(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0, 3, "wrap lh");

    @(posedge clk); #1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h0E;
    mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsts fw stall", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rsts second req", 32'(mem_req), 32'd1);
    chk("rsts second addr", mem_addr, 32'h10);
    @(posedge clk); #1;
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rsts req0", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rsts after req", 32'(mem_req), 32'd0);
    chk("rsts after stall", 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    core_req = 1'b0;
    exp_rq(1'b0, 32'h0C, 4'h0, 32'h0);
    chk_reqs("rsts");
`endif

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Load/store unit that sits directly upstream of data_mem.
- Converts core load/store requests (byte, halfword, word; signed or unsigned) into word-aligned data_mem transactions. Generates mem_be_o and lane-shifted write data, and extracts and extends read data.
- Splits misaligned halfword/word accesses into two consecutive word transactions.
- Stalls the core until the access completes.

Parameters:
- ADDR_W, 32, width of core and memory addresses.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- core_req_i  in  1  access request from the core; core holds all core_* inputs stable while core_stall_o=1.
- core_we_i  in  1  1 = store, 0 = load.
- core_size_i  in  3  access size; LDST_* encoding (funct3).
- core_addr_i  in  ADDR_W  byte address.
- core_wd_i  in  32  store data, right-aligned.
- core_rd_o  out  32  load result, extended.
- core_stall_o  out  1  core must hold its request.
- core_misalign_o  out  1  misaligned-access flag; only meaningful without LSU_MISALIGN_SPLIT_EN.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- mem_wd_o  out  32  lane-shifted store data.
- mem_rd_i  in  32  memory read data, valid the cycle after an accepted read.
- mem_ready_i  in  1  memory accepts the request this cycle.

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_i is synchronous and active-high.
- While rst_i=1, and on the cycle after it, the following outputs read 0: state=IDLE, mem_req_o, core_stall_o, core_misalign_o, and the split buffer.
- off = core_addr_i[1:0]. An access is misaligned when:
  - H/HU with off=3;
  - W with off!=0.
  - B/BU is never misaligned.
- Base enables: B=0001, H=0011, W=1111.
- Store lane data: {core_wd_i, core_wd_i} shifted left by off*8.
- mem_we_o = core_we_i during all phases.
- FSM states: IDLE, FIRST_WAIT, SECOND, SECOND_WAIT.
- Aligned access (2 cycles):
  - IDLE + core_req_i: drive mem_req_o=1, mem_addr_o=addr&~3, mem_be_o = base<<off (writes only), core_stall_o=1.
  - When mem_ready_i=1, go to FIRST_WAIT.
  - FIRST_WAIT: mem_req_o=0, core_stall_o=0; core_rd_o is derived combinationally from mem_rd_i. Next state IDLE.
- Misaligned split access (4 cycles):
  - IDLE: first word at addr&~3, be = (base<<off)[3:0]; go to FIRST_WAIT.
  - FIRST_WAIT: capture mem_rd_i into lo_buf; stall stays 1; go to SECOND.
  - SECOND: issue word at (addr&~3)+4, be = (base<<off)[7:4], upper half of the shifted store data; go to SECOND_WAIT on ready.
  - SECOND_WAIT: core_stall_o=0; read result = ({mem_rd_i, lo_buf} >> off*8)[31:0]; go to IDLE.
- Read extension:
  - B sign-extends bit 7, H sign-extends bit 15.
  - BU/HU zero-extend.
  - W passes through.
- mem_ready_i=0 while a request is driven: hold every mem_* output and the current state; stall stays 1.
- Undefined core_size_i (3, 6, 7): treated as W.
- Second word address wraps modulo 2^ADDR_W.
- core_req_i deasserted in IDLE: no memory activity; mem_req_o=0 and core_stall_o=0.
- Reset mid-split: a pending second transaction is abandoned, no further mem_req_o; a partial store may already be committed.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as above; core_misalign_o is tied to 0.
- Undefined:
  - A misaligned request issues no memory transaction.
  - core_misalign_o=1 and core_stall_o=0 in the same cycle; state stays IDLE.
  - Aligned behaviour is identical to the defined case.

Decomposition:
- LDST_B/H/W/BU/HU encodings live in the existing decoder_pkg, shared with the decoder.
- Also in decoder_pkg: a new typedef lsu_state_t for the FSM states, and a new function be_base(size).
- One natural sub-module: lsu_rd_extract (combinational: off, size, 64-bit window -> extended 32-bit result). It is reused for both the aligned and split paths.

Test Plan:
- Aligned SW, addr 0x10, data 0xDEADBEEF, ready=1 -> mem_addr_o=0x10, be=1111, wd=0xDEADBEEF; stall 1 cycle then 0.
- LB addr 0x13, memory word 0x80FF_0000 -> be not checked, core_rd_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x06, data 0x1234 -> be=1100, wd[31:16]=0x1234; LHU back -> 0x00001234.
- Split LW addr 0x0E, words [0x0C]=0xAABBCCDD and [0x10]=0x11223344:
  - two requests, 0x0C then 0x10;
  - core_rd_o=0x3344AABB;
  - stall high 3 cycles.
- Split SW addr 0x0F, data 0xCAFEF00D -> first be=1000 at 0x0C, second be=0111 at 0x10; reading back via split LW returns 0xCAFEF00D.
- mem_ready_i held 0 for 3 cycles during an aligned LW -> mem_* outputs stable, stall remains 1, data is correct after ready.
- rst_i asserted in SECOND -> next cycle IDLE, mem_req_o=0.
- With macro undefined: LW at 0x0E -> core_misalign_o=1, mem_req_o=0.
